// File: rtl/briscv_program_loader_if.sv
// Byte-stream input and word-wide memory write port of the BRISC-V program loader.
// The loader connects through the slave modport; the system side uses master.
interface briscv_program_loader_if #(
   parameter int DATA_WIDTH       = 32,
   parameter int MEM_ADDRESS_BITS = 10
);
   logic [7:0]                  in_data;
   logic                        in_valid;
   logic                        in_ready;
   logic                        mem_write;
   logic [DATA_WIDTH/8-1:0]     mem_byte_en;
   logic [MEM_ADDRESS_BITS-1:0] mem_address;
   logic [DATA_WIDTH-1:0]       mem_data_out;

   modport master (
      output in_data, in_valid,
      input  in_ready, mem_write, mem_byte_en, mem_address, mem_data_out
   );

   modport slave (
      input  in_data, in_valid,
      output in_ready, mem_write, mem_byte_en, mem_address, mem_data_out
   );
endinterface

// File: rtl/briscv_program_loader.sv
// Loads a framed little-endian program image into memory, holding the core in reset
// until the frame checksum passes, then pulses start with the entry address.
module briscv_program_loader #(
   parameter int DATA_WIDTH       = 32,
   parameter int ADDRESS_BITS     = 32,
   parameter int MEM_ADDRESS_BITS = 10
) (
   input  logic                    clock,
   input  logic                    reset,
   briscv_program_loader_if.slave  bus,
   output logic                    core_reset,
   output logic                    start,
   output logic [ADDRESS_BITS-1:0] program_address,
   output logic                    busy,
   output logic                    error
);
   localparam logic [2:0] HDR_ENTRY = 3'd0;
   localparam logic [2:0] HDR_COUNT = 3'd1;
   localparam logic [2:0] DATA      = 3'd2;
   localparam logic [2:0] CHECK     = 3'd3;
   localparam logic [2:0] START     = 3'd4;
   localparam logic [2:0] DONE      = 3'd5;
   localparam logic [2:0] ERROR     = 3'd6;

   logic [2:0]                  state_reg;
   logic [1:0]                  byte_cnt_reg;
   logic [31:0]                 entry_reg;
   logic [31:0]                 count_reg;
   logic [23:0]                 word_reg;
   logic [7:0]                  sum_reg;
   logic [MEM_ADDRESS_BITS-1:0] index_reg;
   logic                        mem_write_reg;
   logic [MEM_ADDRESS_BITS-1:0] mem_address_reg;
   logic [DATA_WIDTH-1:0]       mem_data_reg;
   logic [ADDRESS_BITS-1:0]     program_address_reg;

   logic                        accept;
   logic [31:0]                 entry_next;
   logic [31:0]                 count_next;
   logic [7:0]                  sum_next;
   logic [DATA_WIDTH/8-1:0]     byte_en;

   assign accept     = bus.in_valid && bus.in_ready;
   assign entry_next = {bus.in_data, entry_reg[31:8]};
   assign count_next = {bus.in_data, count_reg[31:8]};
   assign sum_next   = sum_reg + bus.in_data;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg           <= HDR_ENTRY;
         byte_cnt_reg        <= 2'd0;
         entry_reg           <= '0;
         count_reg           <= '0;
         word_reg            <= '0;
         sum_reg             <= '0;
         index_reg           <= '0;
         mem_write_reg       <= 1'b0;
         mem_address_reg     <= '0;
         mem_data_reg        <= '0;
         program_address_reg <= '0;
      end else begin
         mem_write_reg <= 1'b0;
         if (accept) begin
            case (state_reg)
               HDR_ENTRY: begin
                  entry_reg    <= entry_next;
                  sum_reg      <= sum_next;
                  byte_cnt_reg <= byte_cnt_reg + 2'd1;
                  if (byte_cnt_reg == 2'd3) begin
                     state_reg <= HDR_COUNT;
                     index_reg <= entry_next[MEM_ADDRESS_BITS+1:2];
                  end
               end
               HDR_COUNT: begin
                  count_reg    <= count_next;
                  sum_reg      <= sum_next;
                  byte_cnt_reg <= byte_cnt_reg + 2'd1;
                  if (byte_cnt_reg == 2'd3)
                     state_reg <= (count_next == 32'd0) ? CHECK : DATA;
               end
               DATA: begin
                  sum_reg      <= sum_next;
                  byte_cnt_reg <= byte_cnt_reg + 2'd1;
                  if (byte_cnt_reg != 2'd3) begin
                     word_reg <= {bus.in_data, word_reg[23:8]};
                  end else begin
                     // Registered write; the SUM byte cannot arrive before it reaches memory.
                     mem_write_reg   <= 1'b1;
                     mem_address_reg <= index_reg;
                     mem_data_reg    <= {bus.in_data, word_reg};
                     index_reg       <= index_reg + 1'b1;
                     count_reg       <= count_reg - 32'd1;
                     if (count_reg == 32'd1)
                        state_reg <= CHECK;
                  end
               end
               CHECK: begin
                  sum_reg <= sum_next;
                  if (sum_next == 8'd0) begin
                     state_reg           <= START;
                     program_address_reg <= entry_reg[ADDRESS_BITS-1:0];
                  end else begin
                     state_reg <= ERROR;
                  end
               end
               DONE, ERROR: begin
                  // This byte is already the first ENTRY byte of the next frame.
                  entry_reg    <= entry_next;
                  sum_reg      <= bus.in_data;
                  byte_cnt_reg <= 2'd1;
                  state_reg    <= HDR_ENTRY;
               end
               default: state_reg <= HDR_ENTRY;
            endcase
         end else if (state_reg == START) begin
            state_reg <= DONE;
         end
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < DATA_WIDTH/8; gi++) begin : g_byte_en
         assign byte_en[gi] = mem_write_reg;
      end
   endgenerate

   assign bus.in_ready     = !reset && (state_reg != START);
   assign bus.mem_write    = mem_write_reg;
   assign bus.mem_byte_en  = byte_en;
   assign bus.mem_address  = mem_address_reg;
   assign bus.mem_data_out = mem_data_reg;

   assign core_reset      = !((state_reg == START) || (state_reg == DONE));
   assign start           = (state_reg == START);
   assign program_address = program_address_reg;
   assign busy            = ((state_reg == HDR_ENTRY) && (byte_cnt_reg != 2'd0)) ||
                            (state_reg == HDR_COUNT) || (state_reg == DATA) ||
                            (state_reg == CHECK);
   assign error           = (state_reg == ERROR);
endmodule

// File: tb/tb_briscv_program_loader.sv
// Directed bench for the program loader: expected writes are queued as frames are
// sent and compared against the writes captured from the memory port.
module tb_briscv_program_loader;
   logic        clock;
   logic        reset;
   logic        core_reset;
   logic        start;
   logic [31:0] program_address;
   logic        busy;
   logic        error;

   int vectors = 0;
   int errors  = 0;

   logic [45:0] exp_q[$];
   logic [45:0] got_q[$];
   int          start_cnt = 0;
   logic [31:0] img[8];

   briscv_program_loader_if #(.DATA_WIDTH(32), .MEM_ADDRESS_BITS(10)) bus();

   briscv_program_loader #(
      .DATA_WIDTH(32), .ADDRESS_BITS(32), .MEM_ADDRESS_BITS(10)
   ) dut (
      .clock(clock), .reset(reset), .bus(bus),
      .core_reset(core_reset), .start(start), .program_address(program_address),
      .busy(busy), .error(error)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Capture every write and start pulse mid-cycle.
   always @(negedge clock) begin
      if (bus.mem_write)
         got_q.push_back({bus.mem_byte_en, bus.mem_address, bus.mem_data_out});
      if (start)
         start_cnt = start_cnt + 1;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input bit gaps);
      if (gaps) repeat ($urandom_range(0, 2)) @(negedge clock);
      bus.in_data  = b;
      bus.in_valid = 1'b1;
      #1;
      check("in_ready_before_byte", 64'(bus.in_ready), 64'd1);
      @(posedge clock);
      @(negedge clock);
      bus.in_valid = 1'b0;
   endtask

   task automatic send_frame(input logic [31:0] entry, input int n, input logic [7:0] sum_adj,
                             input bit gaps, input string name);
      logic [7:0] bytes[$];
      logic [7:0] s;
      logic [9:0] idx;
      int         base;
      int         s0;
      bit         good;
      base = got_q.size();
      s0   = start_cnt;
      good = (sum_adj == 8'd0);
      for (int i = 0; i < 4; i++) bytes.push_back(entry[8*i +: 8]);
      for (int i = 0; i < 4; i++) bytes.push_back(8'(n >> (8*i)));
      for (int w = 0; w < n; w++) begin
         for (int i = 0; i < 4; i++) bytes.push_back(img[w][8*i +: 8]);
         idx = 10'((entry >> 2) + 32'(w));
         exp_q.push_back({4'hF, idx, img[w]});
      end
      s = 8'd0;
      foreach (bytes[i]) s = s + bytes[i];
      bytes.push_back(8'(8'd0 - s) + sum_adj);
      foreach (bytes[i]) begin
         send_byte(bytes[i], gaps);
         if (i == 0) begin
            check({name, " core_reset_first_byte"}, 64'(core_reset), 64'd1);
            check({name, " busy_first_byte"}, 64'(busy), 64'd1);
            check({name, " error_first_byte"}, 64'(error), 64'd0);
         end
         if (i == 7) check({name, " busy_in_count"}, 64'(busy), 64'd1);
      end
      if (good) begin
         check({name, " start_pulse"}, 64'(start), 64'd1);
         check({name, " core_reset_released"}, 64'(core_reset), 64'd0);
         check({name, " program_address"}, 64'(program_address), 64'(entry));
         check({name, " in_ready_in_start"}, 64'(bus.in_ready), 64'd0);
         check({name, " error_good"}, 64'(error), 64'd0);
         @(negedge clock);
         check({name, " start_dropped"}, 64'(start), 64'd0);
         check({name, " core_reset_held_low"}, 64'(core_reset), 64'd0);
         check({name, " in_ready_done"}, 64'(bus.in_ready), 64'd1);
         check({name, " program_address_held"}, 64'(program_address), 64'(entry));
      end else begin
         check({name, " error_set"}, 64'(error), 64'd1);
         check({name, " core_reset_held_high"}, 64'(core_reset), 64'd1);
         check({name, " busy_after_error"}, 64'(busy), 64'd0);
         check({name, " no_start_on_error"}, 64'(start), 64'd0);
         @(negedge clock);
      end
      check({name, " start_count"}, 64'(start_cnt - s0), good ? 64'd1 : 64'd0);
      check({name, " write_count"}, 64'(got_q.size() - base), 64'(exp_q.size()));
      for (int i = base; exp_q.size() > 0; i++) begin
         if (i < got_q.size())
            check({name, " write"}, 64'(got_q[i]), 64'(exp_q[0]));
         void'(exp_q.pop_front());
      end
      $display("frame %s: entry=%08h words=%0d sum_adj=%0d gaps=%0d", name, entry, n, sum_adj, gaps);
   endtask

   initial begin
      int base;
      reset        = 1'b1;
      bus.in_valid = 1'b0;
      bus.in_data  = 8'd0;
      @(negedge clock);
      #1;
      check("in_ready_during_reset", 64'(bus.in_ready), 64'd0);
      @(negedge clock);
      reset = 1'b0;
      #1;
      check("rst in_ready", 64'(bus.in_ready), 64'd1);
      check("rst mem_write", 64'(bus.mem_write), 64'd0);
      check("rst mem_byte_en", 64'(bus.mem_byte_en), 64'd0);
      check("rst mem_address", 64'(bus.mem_address), 64'd0);
      check("rst mem_data_out", 64'(bus.mem_data_out), 64'd0);
      check("rst core_reset", 64'(core_reset), 64'd1);
      check("rst start", 64'(start), 64'd0);
      check("rst program_address", 64'(program_address), 64'd0);
      check("rst busy", 64'(busy), 64'd0);
      check("rst error", 64'(error), 64'd0);
      @(negedge clock);

      img[0] = 32'h3fc00093; img[1] = 32'h0000a023; img[2] = 32'h0000a103;
      img[3] = 32'h00110113; img[4] = 32'h0020a023; img[5] = 32'hff5ff06f;
      send_frame(32'h0, 6, 8'd0, 1'b0, "six_words");
      send_frame(32'h0, 6, 8'd1, 1'b0, "bad_sum");

      img[0] = 32'h11223344; img[1] = 32'h55667788;
      send_frame(32'h00000FFC, 2, 8'd0, 1'b0, "wrap");
      send_frame(32'h00000100, 0, 8'd0, 1'b0, "empty");

      img[0] = 32'hA5A5_0001; img[1] = 32'h5A5A_0002; img[2] = 32'hCAFE_0003;
      send_frame(32'h00000020, 3, 8'd0, 1'b0, "three_b2b");
      send_frame(32'h00000020, 3, 8'd0, 1'b1, "three_gaps");

      // Abort a frame after the 2nd data byte of word 1; reset also races a valid byte.
      base = got_q.size();
      for (int i = 0; i < 4; i++) send_byte(8'h00, 1'b0);
      send_byte(8'h01, 1'b0);
      for (int i = 0; i < 3; i++) send_byte(8'h00, 1'b0);
      send_byte(8'h77, 1'b0);
      send_byte(8'h66, 1'b0);
      reset        = 1'b1;
      bus.in_data  = 8'h55;
      bus.in_valid = 1'b1;
      #1;
      check("abort in_ready_in_reset", 64'(bus.in_ready), 64'd0);
      @(negedge clock);
      reset        = 1'b0;
      bus.in_valid = 1'b0;
      #1;
      check("abort mem_write", 64'(bus.mem_write), 64'd0);
      check("abort busy", 64'(busy), 64'd0);
      check("abort core_reset", 64'(core_reset), 64'd1);
      check("abort error", 64'(error), 64'd0);
      check("abort start", 64'(start), 64'd0);
      check("abort program_address", 64'(program_address), 64'd0);
      $display("abort: reset after 2nd data byte, writes seen=%0d", got_q.size() - base);
      @(negedge clock);

      img[0] = 32'hDEADBEEF;
      send_frame(32'h00000040, 1, 8'd0, 1'b0, "after_abort");
      check("after_abort index16", 64'(got_q[got_q.size()-1][41:32]), 64'd16);
      img[0] = 32'h0BADF00D;
      send_frame(32'h00000080, 1, 8'd0, 1'b1, "from_done");

      repeat (3) @(negedge clock);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule

// File: doc/briscv_program_loader.md
# briscv_program_loader

Hardware program loader for the BRISC-V single-core system. It receives a byte-stream program image over a valid/ready interface and writes it word by word into the byte-enabled memory write port. It holds the core in reset while loading, then releases it and pulses `start` with the image entry address. It is the writer-side counterpart of the core's instruction fetch, and replaces backdoor BRAM initialisation on hardware.

## Interface
Parameters:
- `DATA_WIDTH`, 32: memory word width; must be 32.
- `ADDRESS_BITS`, 32: width of `program_address`.
- `MEM_ADDRESS_BITS`, 10: word-index width of the memory write port.

Ports:
- `clock`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `in_data`  in  8  stream byte.
- `in_valid`  in  1  `in_data` valid.
- `in_ready`  out  1  loader accepts a byte; transfer occurs on an edge where `in_valid && in_ready`.
- `mem_write`  out  1  write strobe, one cycle per word.
- `mem_byte_en`  out  DATA_WIDTH/8  byte enables; all ones when `mem_write` is high.
- `mem_address`  out  MEM_ADDRESS_BITS  word index.
- `mem_data_out`  out  DATA_WIDTH  write data.
- `core_reset`  out  1  reset to the core.
- `start`  out  1  one-cycle start pulse to the core.
- `program_address`  out  ADDRESS_BITS  entry address; valid while `start` is high and held afterwards.
- `busy`  out  1  a frame is in progress.
- `error`  out  1  last frame failed its checksum.

## Operation
- Frame format, all multi-byte fields little-endian:
  - ENTRY: 4 bytes.
  - COUNT: 4 bytes, N words.
  - DATA: N×4 bytes.
  - SUM: 1 byte.
- Frame check: (sum of every ENTRY, COUNT and DATA byte + SUM) mod 256 must equal 0.
- States: HDR_ENTRY, HDR_COUNT, DATA, CHECK, START, DONE, ERROR. A 2-bit byte counter tracks the byte position within a field or word.
- HDR_ENTRY: shift 4 bytes into the entry register, then go to HDR_COUNT.
- HDR_COUNT: shift 4 bytes into the remaining-word counter (32 bit). After the 4th byte:
  - N == 0: go to CHECK.
  - Otherwise: go to DATA.
- Write index base: ENTRY[MEM_ADDRESS_BITS+1:2]. It increments after each word and wraps modulo 2^MEM_ADDRESS_BITS.
- DATA: assemble 4 bytes, byte 0 into bits [7:0]. On the 4th byte:
  - Register the write (address, data, byte enables all ones).
  - Decrement the remaining-word count.
  - After word N, go to CHECK.
- CHECK: accept the SUM byte.
  - Total == 0: go to START.
  - Otherwise: go to ERROR with `error` = 1.
- START: lasts one cycle.
  - `core_reset` = 0, `start` = 1, `program_address` = ENTRY.
  - Then go to DONE.
- DONE and ERROR are idle states.
  - A byte accepted in either state is the first ENTRY byte of a new frame: next state HDR_ENTRY with the byte counter at 1.
  - On that byte, `core_reset` goes to 1, `error` clears and `busy` sets.
- `core_reset`:
  - 1 from reset through the whole load.
  - 1 in ERROR.
  - 0 only in START and DONE.
- `busy`: 1 in HDR_ENTRY after at least one byte, and in HDR_COUNT, DATA and CHECK. 0 otherwise.
- `in_ready`:
  - 0 during the cycle `reset` is high.
  - 0 in START.
  - 1 otherwise.
  - Writes never stall input.
- Memory already written is not rolled back on a checksum error or on reset.

## Timing
- Reset values: `in_ready` 0, `mem_write` 0, `mem_byte_en` 0, `mem_address` 0, `mem_data_out` 0, `core_reset` 1, `start` 0, `program_address` 0, `busy` 0, `error` 0, state HDR_ENTRY.
- Write latency:
  - The 4th data byte of a word is accepted at edge k.
  - `mem_write`, `mem_address` and `mem_data_out` are registered and high/valid in the cycle after edge k, sampled by memory at edge k+1.
  - `mem_write` drops after one cycle unless another word completes.
- Back-to-back bytes at one per cycle produce at most one write every 4 cycles. No overlap hazard exists.
- SUM accepted at edge t:
  - Good: `start` = 1 and `core_reset` = 0 during cycle t..t+1, then `start` = 0 with `core_reset` held at 0.
  - Bad: `error` = 1 from edge t.
- The last data word's write completes at least one edge before `start` rises, so the core never fetches unwritten memory.
- Synchronous reset mid-frame: all state returns to reset values at that edge and a partial frame is discarded. A pending registered write is dropped, i.e. `mem_write` = 0 after the reset edge.
- Simultaneous `reset` and `in_valid`: reset wins and the byte is not accepted.
- `in_valid` low mid-field: state and counters hold, with no timeout.
- COUNT greater than 2^MEM_ADDRESS_BITS: indices wrap and overwrite. This is legal and flagged nowhere.

## Test plan
- Load of 6 words at ENTRY 0x0 (li/sw/lw/addi/sw/j loop: 0x3fc00093, 0x0000a023, 0x0000a103, 0x00110113, 0x0020a023, 0xff5ff06f) with correct SUM -> 6 writes to indices 0..5 with matching data and `mem_byte_en` = 4'hF; one-cycle `start`, `program_address` = 0, `core_reset` falls the same cycle, `error` = 0.
- Same frame with SUM+1 -> all 6 writes occur, `error` = 1, `start` never pulses, `core_reset` stays 1, `busy` = 0.
- ENTRY = 0x00000FFC, N = 2, MEM_ADDRESS_BITS = 10 -> writes to index 1023 then 0; `program_address` = 0xFFC.
- N = 0 with correct SUM -> no `mem_write`, `start` pulses 1 cycle after SUM is accepted.
- `in_valid` toggling 1-0-1 randomly through a 3-word frame -> identical writes and result to the back-to-back case; `in_ready` 0 only during the START cycle.
- `reset` asserted after the 2nd data byte of word 1, followed by a fresh valid 1-word frame to ENTRY 0x40 -> no write from the aborted word, index 16 written, `start` with `program_address` = 0x40; a second frame sent from DONE re-asserts `core_reset` on its first byte.
